// File: rtl/ifmap_skew_feeder_if.sv
// Vector input handshake, feed throttle and skewed per-row outputs of ifmap_skew_feeder.
interface ifmap_skew_feeder_if #(
  parameter int NUM_ROW        = 4,
  parameter int IFMAP_BITWIDTH = 16
);
  // Handshake: a vector moves on a rising edge where vec_valid_in && vec_ready_out.
  // Valid never waits on ready; data and last stay stable while valid is high and ready is low.
  logic                                vec_valid_in;
  logic                                vec_ready_out;
  logic [NUM_ROW*IFMAP_BITWIDTH-1:0]   vec_data_in;
  logic                                vec_last_in;
  logic                                feed_enable_in;
  logic [NUM_ROW-1:0]                  ifmap_start_out;
  logic [NUM_ROW-1:0]                  ifmap_enable_out;
  logic [NUM_ROW*IFMAP_BITWIDTH-1:0]   ifmap_data_out;
  logic                                busy_out;
  logic                                tile_done_out;

  modport master (
    output vec_valid_in, vec_data_in, vec_last_in, feed_enable_in,
    input  vec_ready_out, ifmap_start_out, ifmap_enable_out, ifmap_data_out,
           busy_out, tile_done_out
  );

  modport slave (
    input  vec_valid_in, vec_data_in, vec_last_in, feed_enable_in,
    output vec_ready_out, ifmap_start_out, ifmap_enable_out, ifmap_data_out,
           busy_out, tile_done_out
  );
endinterface

// File: rtl/ifmap_skew_feeder.sv
// Buffers ifmap vectors and feeds the systolic array rows with an r-cycle skew on row r,
// bracketing each tile with a start pulse and a tile_done pulse on the last row.
module ifmap_skew_feeder #(
  parameter int NUM_ROW        = 4,
  parameter int IFMAP_BITWIDTH = 16,
  parameter int DEPTH          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ifmap_skew_feeder_if.slave   bus,
  output logic [1:0]           fsm_state_o
);
  localparam int W  = IFMAP_BITWIDTH;
  localparam int VW = NUM_ROW * W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_ROW);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_e;

  state_e        state_q;
  logic [CW-1:0] drain_cnt_q;

  logic [VW:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [VW:0]   head;

  logic [NUM_ROW-1:0] start_q, en_q, done_q;
  logic [VW-1:0]      data_out;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign push  = bus.vec_valid_in && bus.vec_ready_out;
  // The pop taken on the START->STREAM edge is what puts element 0 right behind the start pulse.
  assign pop   = bus.feed_enable_in && !empty && (state_q == START || state_q == STREAM);

  assign bus.vec_ready_out = !full && !rst;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.vec_last_in, bus.vec_data_in};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      start_q     <= '0;
      en_q        <= '0;
      done_q      <= '0;
    end else begin
      start_q <= {start_q[NUM_ROW-2:0], (state_q == IDLE) && !empty};
      en_q    <= {en_q[NUM_ROW-2:0], pop};
      done_q  <= {done_q[NUM_ROW-2:0], pop && head[VW]};
      case (state_q)
        IDLE:   if (!empty) state_q <= START;
        START, STREAM: begin
          if (pop && head[VW]) begin
            state_q     <= DRAIN;
            drain_cnt_q <= CW'(NUM_ROW - 1);
          end else begin
            state_q <= STREAM;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == '0) state_q <= IDLE;
          else                   drain_cnt_q <= drain_cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Row r data rides a private r+1 deep delay line; bubbles load zero so idle rows read 0.
  for (genvar r = 0; r < NUM_ROW; r++) begin : g_lane
    logic [W-1:0] lane_q [r+1];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j <= r; j++) lane_q[j] <= '0;
      end else begin
        lane_q[0] <= pop ? head[r*W +: W] : '0;
        for (int j = 1; j <= r; j++) lane_q[j] <= lane_q[j-1];
      end
    end
    assign data_out[r*W +: W] = lane_q[r];
  end

  assign bus.ifmap_start_out  = start_q;
  assign bus.ifmap_enable_out = en_q;
  assign bus.ifmap_data_out   = data_out;
  assign bus.busy_out         = (state_q != IDLE);
  assign bus.tile_done_out    = done_q[NUM_ROW-1];
  assign fsm_state_o          = state_q;
endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Self-checking bench for ifmap_skew_feeder: edge-timeline model of the skewed wavefront plus
// hand-computed literal expectations for each directed scenario.
module tb_ifmap_skew_feeder;
  localparam int NUM_ROW = 4;
  localparam int W       = 16;
  localparam int DEPTH   = 8;
  localparam int VW      = NUM_ROW * W;
  localparam int RING    = 64;
  localparam int HIST    = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  ifmap_skew_feeder_if #(.NUM_ROW(NUM_ROW), .IFMAP_BITWIDTH(W)) bus ();

  ifmap_skew_feeder #(.NUM_ROW(NUM_ROW), .IFMAP_BITWIDTH(W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fsm_state_o (fsm_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endfunction

  // ---------------- model: FIFO as a queue, outputs scheduled on an edge timeline
  typedef struct packed { logic last; logic [VW-1:0] data; } entry_t;
  entry_t q[$];
  int  edge_n    = 0;
  bit  live      = 1'b0;
  bit  active    = 1'b0;
  int  drain_end = -10;
  bit  busy_exp  = 1'b0;

  logic [NUM_ROW-1:0] x_start [RING];
  logic [NUM_ROW-1:0] x_en    [RING];
  logic [VW-1:0]      x_data  [RING];
  bit                 x_done  [RING];

  logic [NUM_ROW-1:0] h_start [HIST];
  logic [NUM_ROW-1:0] h_en    [HIST];
  logic [VW-1:0]      h_data  [HIST];
  bit                 h_done  [HIST];
  bit                 h_busy  [HIST];
  bit                 h_ready [HIST];

  always @(posedge clk) begin
    int t;
    int sz;
    entry_t e;
    edge_n++;
    t = edge_n;
    if (rst) begin
      live = 1'b1;
      q.delete();
      active    = 1'b0;
      drain_end = -10;
      busy_exp  = 1'b0;
      for (int i = 0; i < RING; i++) begin
        x_start[i] = '0; x_en[i] = '0; x_data[i] = '0; x_done[i] = 1'b0;
      end
    end else begin
      sz = q.size();
      if (!active && t >= drain_end + 2 && sz > 0) begin
        active = 1'b1;
        for (int r = 0; r < NUM_ROW; r++) x_start[(t + r) % RING][r] = 1'b1;
      end else if (active && bus.feed_enable_in && sz > 0) begin
        e = q.pop_front();
        for (int r = 0; r < NUM_ROW; r++) begin
          x_en[(t + r) % RING][r] = 1'b1;
          x_data[(t + r) % RING][r*W +: W] = e.data[r*W +: W];
        end
        if (e.last) begin
          active    = 1'b0;
          drain_end = t + NUM_ROW - 1;
          x_done[drain_end % RING] = 1'b1;
        end
      end
      if (bus.vec_valid_in && sz < DEPTH) q.push_back({bus.vec_last_in, bus.vec_data_in});
      busy_exp = active || (t <= drain_end);
    end
  end

  // ---------------- scoreboard compare, mid-cycle
  always @(negedge clk) begin
    int s;
    if (live) begin
      s = edge_n % RING;
      chk("start",  bus.ifmap_start_out,  x_start[s]);
      chk("enable", bus.ifmap_enable_out, x_en[s]);
      chk("data",   bus.ifmap_data_out,   x_data[s]);
      chk("done",   bus.tile_done_out,    x_done[s]);
      chk("busy",   bus.busy_out,         busy_exp);
      chk("idle_state", fsm_state == 2'd0, !busy_exp);
      chk("ready",  bus.vec_ready_out,    (q.size() < DEPTH) && !rst);
      h_start[edge_n % HIST] = bus.ifmap_start_out;
      h_en[edge_n % HIST]    = bus.ifmap_enable_out;
      h_data[edge_n % HIST]  = bus.ifmap_data_out;
      h_done[edge_n % HIST]  = bus.tile_done_out;
      h_busy[edge_n % HIST]  = bus.busy_out;
      h_ready[edge_n % HIST] = bus.vec_ready_out;
      x_start[s] = '0; x_en[s] = '0; x_data[s] = '0; x_done[s] = 1'b0;
    end
  end

  // ---------------- drivers
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [VW-1:0] d, input logic l);
    bus.vec_valid_in = 1'b1;
    bus.vec_data_in  = d;
    bus.vec_last_in  = l;
    step();
    bus.vec_valid_in = 1'b0;
    bus.vec_data_in  = '0;
    bus.vec_last_in  = 1'b0;
  endtask

  function automatic logic [VW-1:0] mk(input int k);
    logic [VW-1:0] v;
    for (int r = 0; r < NUM_ROW; r++) v[r*W +: W] = W'(16 * k + r);
    return v;
  endfunction

  function automatic logic [W-1:0] row(input int e, input int r);
    logic [VW-1:0] v;
    v = h_data[e % HIST];
    return v[r*W +: W];
  endfunction

  int e0, p0, cnt;

  initial begin
    rst = 1'b1;
    bus.vec_valid_in   = 1'b0;
    bus.vec_data_in    = '0;
    bus.vec_last_in    = 1'b0;
    bus.feed_enable_in = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("init_ready", bus.vec_ready_out, 1);
    chk("init_busy",  bus.busy_out, 0);
    step();

    // Contiguous 3-vector tile
    bus.feed_enable_in = 1'b1;
    push(mk(0), 1'b0); e0 = edge_n;
    push(mk(1), 1'b0);
    push(mk(2), 1'b1);
    repeat (10) step();
    chk("t2_r0_start", h_start[(e0+1) % HIST][0], 1);
    chk("t2_r0_e0",    row(e0+2, 0), 0);
    chk("t2_r0_e1",    row(e0+3, 0), 16);
    chk("t2_r0_e2",    row(e0+4, 0), 32);
    chk("t2_r3_start", h_start[(e0+4) % HIST][3], 1);
    chk("t2_r3_e0",    row(e0+5, 3), 3);
    chk("t2_r3_e1",    row(e0+6, 3), 19);
    chk("t2_r3_e2",    row(e0+7, 3), 35);
    chk("t2_r3_en",    h_en[(e0+5) % HIST][3], 1);
    chk("t2_done",     h_done[(e0+7) % HIST], 1);
    chk("t2_done_pre", h_done[(e0+6) % HIST], 0);
    chk("t2_done_post",h_done[(e0+8) % HIST], 0);

    // One-cycle stall after the first element
    push(mk(0), 1'b0); e0 = edge_n;
    push(mk(1), 1'b0);
    push(mk(2), 1'b1);
    bus.feed_enable_in = 1'b0;
    step();
    bus.feed_enable_in = 1'b1;
    repeat (10) step();
    chk("t3_r0_gap",  h_en[(e0+3) % HIST][0], 0);
    chk("t3_r0_e1",   row(e0+4, 0), 16);
    chk("t3_r3_gap",  h_en[(e0+6) % HIST][3], 0);
    chk("t3_r3_e2",   row(e0+8, 3), 35);
    chk("t3_done",    h_done[(e0+8) % HIST], 1);
    chk("t3_done_pre",h_done[(e0+7) % HIST], 0);

    // Fill the FIFO with the array stalled
    bus.feed_enable_in = 1'b0;
    for (int k = 0; k < DEPTH; k++) push(mk(k + 8), k == DEPTH - 1);
    #1;
    chk("t4_full_ready", bus.vec_ready_out, 0);
    bus.vec_valid_in = 1'b1;
    bus.vec_data_in  = mk(99);
    step(); step();
    bus.vec_valid_in = 1'b0;
    bus.vec_data_in  = '0;
    chk("t4_still_full", bus.vec_ready_out, 0);
    bus.feed_enable_in = 1'b1;
    step(); p0 = edge_n;
    chk("t4_ready_back", bus.vec_ready_out, 1);
    repeat (16) step();
    chk("t4_first_out", row(p0, 0), 128);
    chk("t4_last_out",  row(p0+7+3, 3), 15*16+3);
    chk("t4_done",      h_done[(p0+10) % HIST], 1);

    // Extremes and zero data
    push({16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF}, 1'b0); e0 = edge_n;
    push('0, 1'b1);
    repeat (10) step();
    chk("t5_r0_ffff", row(e0+2, 0), 16'hFFFF);
    chk("t5_r1_8000", row(e0+3, 1), 16'h8000);
    chk("t5_r2_7fff", row(e0+4, 2), 16'h7FFF);
    chk("t5_r3_zero", row(e0+5, 3), 16'h0000);
    chk("t5_r3_en",   h_en[(e0+5) % HIST][3], 1);
    chk("t5_r0_zero_en", h_en[(e0+3) % HIST][0], 1);
    chk("t5_r0_bubble",   h_en[(e0+4) % HIST][0], 0);

    // Back-to-back 2-vector tiles
    push(mk(20), 1'b0); e0 = edge_n;
    push(mk(21), 1'b1);
    push(mk(22), 1'b0);
    push(mk(23), 1'b1);
    repeat (20) step();
    chk("t6_done1",      h_done[(e0+6) % HIST], 1);
    chk("t6_idle_gap",   h_busy[(e0+7) % HIST], 0);
    chk("t6_no_early",   h_start[(e0+7) % HIST], 0);
    chk("t6_start2",     h_start[(e0+8) % HIST][0], 1);
    chk("t6_done2",      h_done[(e0+13) % HIST], 1);
    cnt = 0;
    for (int i = e0; i <= e0 + 20; i++) cnt += int'(h_done[i % HIST]);
    chk("t6_done_count", cnt, 2);

    // Reset in the middle of a tile
    push(mk(30), 1'b0); e0 = edge_n;
    push(mk(31), 1'b0);
    push(mk(32), 1'b1);
    step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("t1_rst_ready",  h_ready[(e0+4) % HIST], 0);
    chk("t1_rst_en",     h_en[(e0+5) % HIST], 0);
    chk("t1_rst_data",   h_data[(e0+5) % HIST], 0);
    chk("t1_ready_rel",  bus.vec_ready_out, 1);
    chk("t1_busy_rel",   bus.busy_out, 0);
    repeat (8) step();
    cnt = 0;
    for (int i = e0 + 4; i <= e0 + 13; i++) cnt += int'(h_done[i % HIST]) + int'(h_start[i % HIST] != '0);
    chk("t1_no_activity", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
